// File: rtl/cacheline_adaptor.sv
// Bridges a whole-line cache fill/writeback interface to a 64-bit, four-beat burst memory port.
// Beats are counted on resp_i, so the memory side may insert idle cycles inside a burst.
module cacheline_adaptor #(
    parameter int unsigned s_line  = 256,
    parameter int unsigned s_burst = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [s_line-1:0]    line_i,
    output logic [s_line-1:0]    line_o,
    input  logic [31:0]          address_i,
    input  logic                 read_i,
    input  logic                 write_i,
    output logic                 resp_o,
    input  logic [s_burst-1:0]   burst_i,
    output logic [s_burst-1:0]   burst_o,
    output logic [31:0]          address_o,
    output logic                 read_o,
    output logic                 write_o,
    input  logic                 resp_i
);

    localparam int unsigned BEATS = s_line / s_burst;
    localparam int unsigned CNT_W = $clog2(BEATS);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t               state_q, state_n;
    logic [CNT_W-1:0]     cnt_q, cnt_n;
    logic [s_line-1:0]    wline_q, wline_n;
    logic [s_line-1:0]    fill_n;
    logic [31:0]          addr_n;
    logic [s_burst-1:0]   burst_n;
    logic                 read_n, write_n, resp_n;

    // Line offset bits are never forwarded to memory.
    logic                 addr_unused;
    assign addr_unused = ^address_i[4:0];

    // State, counter, latched request and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            wline_q   <= '0;
            line_o    <= '0;
            address_o <= '0;
            burst_o   <= '0;
            read_o    <= 1'b0;
            write_o   <= 1'b0;
            resp_o    <= 1'b0;
        end else begin
            state_q   <= state_n;
            cnt_q     <= cnt_n;
            wline_q   <= wline_n;
            line_o    <= fill_n;
            address_o <= addr_n;
            burst_o   <= burst_n;
            read_o    <= read_n;
            write_o   <= write_n;
            resp_o    <= resp_n;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        wline_n = wline_q;
        fill_n  = line_o;
        addr_n  = address_o;
        burst_n = burst_o;
        read_n  = 1'b0;
        write_n = 1'b0;
        resp_n  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (write_i) begin
                    wline_n = line_i;
                    addr_n  = {address_i[31:5], 5'b0};
                    cnt_n   = '0;
                    state_n = WRITE;
                end else if (read_i) begin
                    addr_n  = {address_i[31:5], 5'b0};
                    cnt_n   = '0;
                    state_n = READ;
                end
            end
            READ: begin
                if (resp_i) begin
                    for (int b = 0; b < BEATS; b++) begin
                        if (cnt_q == CNT_W'(b)) fill_n[b*s_burst +: s_burst] = burst_i;
                    end
                    cnt_n = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_BEAT) state_n = DONE;
                end
            end
            WRITE: begin
                if (resp_i) begin
                    cnt_n = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_BEAT) state_n = DONE;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // Present the beat the memory will accept next; hold the last one otherwise.
        if (state_n == WRITE) begin
            for (int b = 0; b < BEATS; b++) begin
                if (cnt_n == CNT_W'(b)) burst_n = wline_n[b*s_burst +: s_burst];
            end
        end

        read_n  = (state_n == READ);
        write_n = (state_n == WRITE);
        resp_n  = (state_n == DONE);
    end

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Directed bench for cacheline_adaptor: a cycle-vector table for the burst protocol,
// then hand-written sequences for reset mid-burst and back-to-back response spacing.
module tb_cacheline_adaptor;

    logic         clk = 1'b0;
    logic         rst;
    logic [255:0] line_i;
    logic [255:0] line_o;
    logic [31:0]  address_i;
    logic         read_i;
    logic         write_i;
    logic         resp_o;
    logic [63:0]  burst_i;
    logic [63:0]  burst_o;
    logic [31:0]  address_o;
    logic         read_o;
    logic         write_o;
    logic         resp_i;

    int errors = 0;
    int checks = 0;

    cacheline_adaptor dut (
        .clk       (clk),
        .rst       (rst),
        .line_i    (line_i),
        .line_o    (line_o),
        .address_i (address_i),
        .read_i    (read_i),
        .write_i   (write_i),
        .resp_o    (resp_o),
        .burst_i   (burst_i),
        .burst_o   (burst_o),
        .address_o (address_o),
        .read_o    (read_o),
        .write_o   (write_o),
        .resp_i    (resp_i)
    );

    always #5 clk = ~clk;

    // Inputs applied for one cycle; expectations are the outputs of the following cycle.
    typedef struct {
        logic        rst;
        logic        rd;
        logic        wr;
        logic        rsp;
        logic [63:0] bi;
        logic        e_rd;
        logic        e_wr;
        logic        e_resp;
        logic        chk_b;
        logic [63:0] e_b;
    } vec_t;

    vec_t vecs[$];

    localparam logic [63:0] B11 = 64'h1111_1111_1111_1111;
    localparam logic [63:0] B22 = 64'h2222_2222_2222_2222;
    localparam logic [63:0] B33 = 64'h3333_3333_3333_3333;
    localparam logic [63:0] B44 = 64'h4444_4444_4444_4444;
    localparam logic [63:0] WA  = 64'hAAAA_AAAA_AAAA_AAAA;
    localparam logic [63:0] WB  = 64'hBBBB_BBBB_BBBB_BBBB;
    localparam logic [63:0] WC  = 64'hCCCC_CCCC_CCCC_CCCC;
    localparam logic [63:0] WD  = 64'hDDDD_DDDD_DDDD_DDDD;

    task automatic add(input logic r, input logic rd, input logic wr, input logic rsp,
                       input logic [63:0] bi, input logic e_rd, input logic e_wr,
                       input logic e_resp, input logic chk_b, input logic [63:0] e_b);
        vec_t v;
        v.rst = r; v.rd = rd; v.wr = wr; v.rsp = rsp; v.bi = bi;
        v.e_rd = e_rd; v.e_wr = e_wr; v.e_resp = e_resp; v.chk_b = chk_b; v.e_b = e_b;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic rd, input logic wr, input logic rsp,
                         input logic [63:0] bi);
        rst = r; read_i = rd; write_i = wr; resp_i = rsp; burst_i = bi;
    endtask

    int t_first;
    int t_second;
    int phase;
    logic [255:0] exp_line;

    initial begin
        drive(1'b1, 1'b0, 1'b0, 1'b0, '0);
        address_i = 32'h1234_5678;
        line_i    = {WD, WC, WB, WA};
        step();

        //   rst   rd    wr    rsp   burst_i  e_rd  e_wr  e_resp chk_b e_burst
        add(1'b1, 1'b0, 1'b0, 1'b0, '0,   1'b0, 1'b0, 1'b0, 1'b1, 64'h0);
        add(1'b0, 1'b1, 1'b0, 1'b0, '0,   1'b1, 1'b0, 1'b0, 1'b0, 64'h0);
        add(1'b0, 1'b1, 1'b0, 1'b1, B11,  1'b1, 1'b0, 1'b0, 1'b0, 64'h0);
        add(1'b0, 1'b1, 1'b0, 1'b1, B22,  1'b1, 1'b0, 1'b0, 1'b0, 64'h0);
        add(1'b0, 1'b1, 1'b0, 1'b1, B33,  1'b1, 1'b0, 1'b0, 1'b0, 64'h0);
        add(1'b0, 1'b1, 1'b0, 1'b1, B44,  1'b0, 1'b0, 1'b1, 1'b0, 64'h0);
        add(1'b0, 1'b1, 1'b0, 1'b1, '1,   1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
        add(1'b0, 1'b0, 1'b0, 1'b1, 64'hEE, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
        add(1'b0, 1'b0, 1'b1, 1'b0, '0,   1'b0, 1'b1, 1'b0, 1'b1, WA);
        add(1'b0, 1'b0, 1'b1, 1'b1, '0,   1'b0, 1'b1, 1'b0, 1'b1, WB);
        add(1'b0, 1'b0, 1'b1, 1'b0, '0,   1'b0, 1'b1, 1'b0, 1'b1, WB);
        add(1'b0, 1'b0, 1'b1, 1'b1, '0,   1'b0, 1'b1, 1'b0, 1'b1, WC);
        add(1'b0, 1'b0, 1'b1, 1'b0, '0,   1'b0, 1'b1, 1'b0, 1'b1, WC);
        add(1'b0, 1'b0, 1'b1, 1'b0, '0,   1'b0, 1'b1, 1'b0, 1'b1, WC);
        add(1'b0, 1'b0, 1'b1, 1'b1, '0,   1'b0, 1'b1, 1'b0, 1'b1, WD);
        add(1'b0, 1'b0, 1'b1, 1'b1, '0,   1'b0, 1'b0, 1'b1, 1'b0, 64'h0);
        add(1'b0, 1'b0, 1'b1, 1'b0, '0,   1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
        add(1'b0, 1'b0, 1'b0, 1'b0, '0,   1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
        add(1'b0, 1'b1, 1'b1, 1'b0, '0,   1'b0, 1'b1, 1'b0, 1'b1, WA);
        add(1'b0, 1'b1, 1'b1, 1'b1, '0,   1'b0, 1'b1, 1'b0, 1'b1, WB);
        add(1'b0, 1'b1, 1'b1, 1'b1, '0,   1'b0, 1'b1, 1'b0, 1'b1, WC);
        add(1'b0, 1'b1, 1'b1, 1'b1, '0,   1'b0, 1'b1, 1'b0, 1'b1, WD);
        add(1'b0, 1'b1, 1'b1, 1'b1, '0,   1'b0, 1'b0, 1'b1, 1'b0, 64'h0);
        add(1'b0, 1'b0, 1'b0, 1'b0, '0,   1'b0, 1'b0, 1'b0, 1'b0, 64'h0);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].rd, vecs[i].wr, vecs[i].rsp, vecs[i].bi);
            step();
            chk($sformatf("vec%0d read_o", i),  256'(read_o),  256'(vecs[i].e_rd));
            chk($sformatf("vec%0d write_o", i), 256'(write_o), 256'(vecs[i].e_wr));
            chk($sformatf("vec%0d resp_o", i),  256'(resp_o),  256'(vecs[i].e_resp));
            if (vecs[i].chk_b) chk($sformatf("vec%0d burst_o", i), 256'(burst_o), 256'(vecs[i].e_b));
            if (i == 0) begin
                chk("reset line_o", line_o, '0);
                chk("reset address_o", 256'(address_o), '0);
            end
        end

        // Fill line survives spurious beats and the following writes.
        chk("read line_o", line_o, {B44, B33, B22, B11});
        chk("address_o aligned", 256'(address_o), 256'(32'h1234_5660));

        // Reset in the middle of a read, with the request address changing under it.
        address_i = 32'hABCD_EF1F;
        drive(1'b0, 1'b1, 1'b0, 1'b0, '0);
        step();
        chk("rst-seq read_o", 256'(read_o), 256'(1'b1));
        address_i = 32'h0;
        drive(1'b0, 1'b1, 1'b0, 1'b1, 64'h7777_7777_7777_7777);
        step();
        drive(1'b0, 1'b1, 1'b0, 1'b1, 64'h8888_8888_8888_8888);
        step();
        chk("rst-seq address_o held", 256'(address_o), 256'(32'hABCD_EF00));
        chk("rst-seq partial line", 256'(line_o[127:0]), 256'({64'h8888_8888_8888_8888, 64'h7777_7777_7777_7777}));
        drive(1'b1, 1'b1, 1'b0, 1'b0, '0);
        step();
        chk("rst-seq read_o", 256'(read_o), 256'(1'b0));
        chk("rst-seq resp_o", 256'(resp_o), 256'(1'b0));
        chk("rst-seq line_o", line_o, '0);
        chk("rst-seq address_o", 256'(address_o), '0);

        // Fresh read after reset takes all four new beats.
        address_i = 32'h0000_1040;
        drive(1'b0, 1'b1, 1'b0, 1'b0, '0);
        step();
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b1, {8{8'(8'h50 + 8'(k))}});
            step();
            chk($sformatf("fresh beat%0d resp_o", k), 256'(resp_o), 256'(k == 3));
        end
        chk("fresh line_o", line_o, {{8{8'h53}}, {8{8'h52}}, {8{8'h51}}, {8{8'h50}}});
        chk("fresh address_o", 256'(address_o), 256'(32'h0000_1040));
        drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
        step();

        // Back-to-back read then write with memory always strobing.
        exp_line = {4{64'h5A5A_5A5A_5A5A_5A5A}};
        t_first = -1;
        t_second = -1;
        phase = 0;
        for (int cyc = 0; cyc < 40 && phase < 2; cyc++) begin
            drive(1'b0, phase == 0, phase == 1, 1'b1, 64'h5A5A_5A5A_5A5A_5A5A);
            step();
            if (phase == 1) chk($sformatf("b2b cyc%0d read_o low", cyc), 256'(read_o), '0);
            if (resp_o) begin
                if (phase == 0) t_first = cyc;
                else t_second = cyc;
                phase++;
            end
        end
        chk("b2b both responses seen", 256'(phase), 256'(2));
        chk("b2b resp spacing", 256'(t_second - t_first), 256'(6));
        chk("b2b line_o untouched by write", line_o, exp_line);
        drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
        step();
        chk("b2b idle resp_o", 256'(resp_o), '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cacheline_adaptor.md
# cacheline_adaptor

Bridges the 256-bit line interface of the data cache datapath (whole-line fill and writeback with a line-aligned address) to a 64-bit burst physical memory port. Each line transfer is four 64-bit beats. Sits directly downstream of the cache: the cache's memory-side read, write, address and line data drive this block, and this block returns the fill line and a one-cycle completion pulse.

## Interface
Parameters:
- s_line, 256, line width in bits
- s_burst, 64, beat width in bits; beats per line = s_line/s_burst = 4

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset; synchronous, active-high
- line_i  in  s_line  writeback line from the cache
- line_o  out  s_line  assembled fill line to the cache
- address_i  in  32  line address from the cache
- read_i  in  1  line fill request; held until resp_o
- write_i  in  1  line writeback request; held until resp_o
- resp_o  out  1  one-cycle completion pulse
- burst_i  in  s_burst  read beat from memory
- burst_o  out  s_burst  write beat to memory
- address_o  out  32  line address to memory, low 5 bits forced to 0
- read_o  out  1  memory burst read request
- write_o  out  1  memory burst write request
- resp_i  in  1  memory beat strobe; one per accepted or returned beat

## Operation
- States: IDLE, READ, WRITE, DONE. 2-bit beat counter cnt.
- IDLE: if write_i, latch line_i and address_i, cnt=0, go WRITE. Else if read_i, latch address_i, cnt=0, go READ. write_i has priority when both are high. resp_i is ignored.
- READ: read_o=1. On each resp_i, store burst_i in line_o[cnt*64 +: 64], so beat 0 fills bits 63:0. Then cnt++. On the resp_i with cnt==3, go DONE.
- WRITE: write_o=1. burst_o=latched_line[cnt*64 +: 64]. On each resp_i, cnt++. On the resp_i with cnt==3, go DONE.
- DONE: resp_o=1 for exactly one cycle, then go IDLE. read_o and write_o are 0. Requests are not sampled in DONE.
- resp_i gaps inside a burst are legal. cnt advances only on resp_i, so beats need not be consecutive.
- address_o = {latched_address[31:5], 5'b0}. It is constant from the first READ/WRITE cycle through DONE.
- line_o is stable after DONE and holds until the next READ overwrites it. It is not modified by WRITE.
- Request inputs that change during READ/WRITE are ignored. The transfer always completes four beats.

## Timing
- Reset values: state=IDLE, cnt=0, resp_o=0, read_o=0, write_o=0, line_o=0, address_o=0, burst_o=0.
- Reset mid-transfer: on the next edge, state returns to IDLE and all outputs take their reset values. The partial line is discarded.
- A request sampled in IDLE at edge E raises read_o/write_o in the cycle following E. Outputs are registered or decoded from the state; there is no combinational path from read_i/write_i to read_o/write_o.
- Read with back-to-back resp_i starting in the first READ cycle: request seen at cycle 0, read_o high in cycles 1-4, resp_o high in cycle 5, idle in cycle 6. Minimum request-to-resp_o is 5 cycles. Each gap cycle in resp_i adds one cycle.
- Write has the same cycle counts. burst_o changes on the edge following each resp_i.
- The earliest next request is accepted in the IDLE cycle after DONE. Minimum spacing between resp_o pulses is 6 cycles.

## Test plan
- Read, consecutive beats: read_i=1, address_i=0x1234_5678, burst_i=0x...11, 0x...22, 0x...33, 0x...44 on 4 consecutive resp_i -> address_o=0x1234_5660; line_o={0x..44,0x..33,0x..22,0x..11}; resp_o is a single pulse in cycle 5.
- Write with gaps: write_i=1, line_i=256'hDDDD..CCCC..BBBB..AAAA; resp_i pattern 1,0,1,0,0,1,1 -> burst_o shows AAAA, BBBB, CCCC, DDDD in order, each held until its resp_i; resp_o on the cycle after the 4th resp_i; write_o low in that cycle.
- Simultaneous request: read_i=write_i=1 -> write_o asserts and read_o stays 0 throughout; exactly one resp_o.
- Reset mid-read: rst after 2 beats -> next cycle read_o=0, line_o=0, no resp_o; a fresh read then completes with all four new beats.
- Spurious resp_i in IDLE or DONE -> no state change and no line_o update. Back-to-back read then write -> resp_o pulses exactly 6 cycles apart, and line_o is unchanged by the write.
